matrix_row_ram: RTL and testbench

- Parametrised dual-port row memory holding the working matrix for the Jacobi rotation datapath.
- Each word is one matrix row of N_ELEM elements of ELEM_W bits.
- Adds element-granular writes, a fixed read-valid timing, a defined write-collision policy and a self-clearing sequence after reset.
- Sits between the rotation engine (port A) and the load/unload controller (port B).

---
 rtl/matrix_ram_pkg.sv | 17 +
 rtl/row_elem_merge.sv | 27 ++
 rtl/matrix_row_ram.sv | 145 ++++++++++++++
 tb/tb_matrix_row_ram.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_ram_pkg.sv
// Shared defaults, row-width helper and controller state type for the Jacobi row memory.
package matrix_ram_pkg;

  localparam int unsigned DefaultElemW = 32;
  localparam int unsigned DefaultNElem = 32;
  localparam int unsigned DefaultDepth = 32;

  function automatic int unsigned row_w(input int unsigned elem_w, input int unsigned n_elem);
    return elem_w * n_elem;
  endfunction

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/row_elem_merge.sv
// Builds the row that results from applying one port's write (full row or one element) to a row.
module row_elem_merge
  import matrix_ram_pkg::*;
#(
  parameter int unsigned ELEM_W = DefaultElemW,
  parameter int unsigned N_ELEM = DefaultNElem,
  parameter int unsigned IDX_W  = $clog2(N_ELEM)
) (
  input  logic [ELEM_W*N_ELEM-1:0] old_row,
  input  logic [ELEM_W*N_ELEM-1:0] wdata,
  input  logic [IDX_W-1:0]         idx,
  input  logic                     elem,
  output logic [ELEM_W*N_ELEM-1:0] new_row
);

  always_comb begin
    new_row = old_row;
    if (elem) begin
      for (int i = 0; i < N_ELEM; i++) begin
        if (idx == IDX_W'(i)) new_row[i*ELEM_W +: ELEM_W] = wdata[ELEM_W-1:0];
      end
    end else begin
      new_row = wdata;
    end
  end

endmodule

// File: rtl/matrix_row_ram.sv
// Dual-port row memory for the Jacobi rotation datapath: element/row writes, read-first,
// port A wins collisions, and the whole array is zeroed after every reset.
module matrix_row_ram
  import matrix_ram_pkg::*;
#(
  parameter int unsigned ELEM_W = DefaultElemW,
  parameter int unsigned N_ELEM = DefaultNElem,
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned IDX_W  = $clog2(N_ELEM)
) (
  input  logic                                clk,
  input  logic                                reset,
  output logic                                busy,
  input  logic                                a_en,
  input  logic                                a_we,
  input  logic                                a_elem,
  input  logic [ADDR_W-1:0]                   a_addr,
  input  logic [IDX_W-1:0]                    a_idx,
  input  logic [row_w(ELEM_W, N_ELEM)-1:0]    a_wdata,
  output logic [row_w(ELEM_W, N_ELEM)-1:0]    a_rdata,
  output logic                                a_rvalid,
  input  logic                                b_en,
  input  logic                                b_we,
  input  logic                                b_elem,
  input  logic [ADDR_W-1:0]                   b_addr,
  input  logic [IDX_W-1:0]                    b_idx,
  input  logic [row_w(ELEM_W, N_ELEM)-1:0]    b_wdata,
  output logic [row_w(ELEM_W, N_ELEM)-1:0]    b_rdata,
  output logic                                b_rvalid
);

  localparam int unsigned ROW_W = row_w(ELEM_W, N_ELEM);

  logic [ROW_W-1:0]  mem [DEPTH];
  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              busy_q, a_rvalid_q, b_rvalid_q;
  logic [ROW_W-1:0]  a_rdata_q, b_rdata_q;

  logic a_addr_ok, b_addr_ok, a_idx_ok, b_idx_ok;

  // Range checks collapse to constants when the address/index space is fully populated.
  if (DEPTH == (1 << ADDR_W)) begin : g_addr_full
    assign a_addr_ok = 1'b1;
    assign b_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign a_addr_ok = (a_addr < ADDR_W'(DEPTH));
    assign b_addr_ok = (b_addr < ADDR_W'(DEPTH));
  end

  if (N_ELEM == (1 << IDX_W)) begin : g_idx_full
    assign a_idx_ok = 1'b1;
    assign b_idx_ok = 1'b1;
  end else begin : g_idx_part
    assign a_idx_ok = (a_idx < IDX_W'(N_ELEM));
    assign b_idx_ok = (b_idx < IDX_W'(N_ELEM));
  end

  logic idle, a_rd, b_rd, a_wr, b_wr, same_row;
  logic [ROW_W-1:0] a_old_row, a_old_mem, b_old_mem, a_new_row, b_new_row;

  assign idle     = (state_q == IDLE);
  assign a_rd     = idle && a_en && !a_we;
  assign b_rd     = idle && b_en && !b_we;
  assign a_wr     = idle && a_en && a_we && a_addr_ok && (!a_elem || a_idx_ok);
  assign b_wr     = idle && b_en && b_we && b_addr_ok && (!b_elem || b_idx_ok);
  assign same_row = (a_addr == b_addr);

  assign a_old_mem = a_addr_ok ? mem[a_addr] : '0;
  assign b_old_mem = b_addr_ok ? mem[b_addr] : '0;
  // Port A merges on top of port B's result, so A wins any overlapping bits.
  assign a_old_row = (b_wr && same_row) ? b_new_row : a_old_mem;

  row_elem_merge #(
    .ELEM_W (ELEM_W),
    .N_ELEM (N_ELEM),
    .IDX_W  (IDX_W)
  ) u_merge_b (
    .old_row (b_old_mem),
    .wdata   (b_wdata),
    .idx     (b_idx),
    .elem    (b_elem),
    .new_row (b_new_row)
  );

  row_elem_merge #(
    .ELEM_W (ELEM_W),
    .N_ELEM (N_ELEM),
    .IDX_W  (IDX_W)
  ) u_merge_a (
    .old_row (a_old_row),
    .wdata   (a_wdata),
    .idx     (a_idx),
    .elem    (a_elem),
    .new_row (a_new_row)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem[clr_cnt_q] <= '0;
      end else begin
        if (b_wr && !(a_wr && same_row)) mem[b_addr] <= b_new_row;
        if (a_wr) mem[a_addr] <= a_new_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b1;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_rd;
      b_rvalid_q <= b_rd;
      unique case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (a_rd) a_rdata_q <= a_old_mem;
          if (b_rd) b_rdata_q <= b_old_mem;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign busy     = busy_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_matrix_row_ram.sv
// Randomised and directed checks of matrix_row_ram against a row-array reference model.
module tb_matrix_row_ram;

  localparam int unsigned ElemW = 32;
  localparam int unsigned NElem = 32;
  localparam int unsigned Depth = 32;
  localparam int unsigned AddrW = 5;
  localparam int unsigned IdxW  = 5;
  localparam int unsigned RowW  = ElemW * NElem;

  logic             clk = 1'b0;
  logic             reset;
  logic             busy;
  logic             a_en, a_we, a_elem, b_en, b_we, b_elem;
  logic [AddrW-1:0] a_addr, b_addr;
  logic [IdxW-1:0]  a_idx, b_idx;
  logic [RowW-1:0]  a_wdata, b_wdata, a_rdata, b_rdata;
  logic             a_rvalid, b_rvalid;

  matrix_row_ram #(
    .ELEM_W (ElemW),
    .N_ELEM (NElem),
    .DEPTH  (Depth)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .a_en     (a_en),
    .a_we     (a_we),
    .a_elem   (a_elem),
    .a_addr   (a_addr),
    .a_idx    (a_idx),
    .a_wdata  (a_wdata),
    .a_rdata  (a_rdata),
    .a_rvalid (a_rvalid),
    .b_en     (b_en),
    .b_we     (b_we),
    .b_elem   (b_elem),
    .b_addr   (b_addr),
    .b_idx    (b_idx),
    .b_wdata  (b_wdata),
    .b_rdata  (b_rdata),
    .b_rvalid (b_rvalid)
  );

  always #5 clk = ~clk;

  logic [RowW-1:0] ref_mem [Depth];
  logic [RowW-1:0] exp_a, exp_b;
  int              busy_left;
  int              n_vec = 0;
  int              n_err = 0;

  task automatic check(input string tag, input logic [RowW-1:0] got, input logic [RowW-1:0] exp);
    int e;
    n_vec++;
    if (got !== exp) begin
      n_err++;
      e = 0;
      for (int i = NElem - 1; i >= 0; i--) begin
        if (got[i*ElemW +: ElemW] !== exp[i*ElemW +: ElemW]) e = i;
      end
      $display("FAIL %s: elem %0d got %h expected %h", tag, e, got[e*ElemW +: ElemW],
               exp[e*ElemW +: ElemW]);
    end
  endtask

  function automatic logic [RowW-1:0] apply_write(input logic [RowW-1:0] row, input logic elem,
                                                   input int idx, input logic [RowW-1:0] wd);
    logic [RowW-1:0] r;
    r = row;
    if (elem) r[idx*ElemW +: ElemW] = wd[ElemW-1:0];
    else r = wd;
    return r;
  endfunction

  function automatic logic [RowW-1:0] rand_row();
    logic [RowW-1:0] r;
    for (int i = 0; i < NElem; i++) r[i*ElemW +: ElemW] = $urandom;
    return r;
  endfunction

  task automatic idle_ports();
    a_en = 0; a_we = 0; a_elem = 0; a_addr = '0; a_idx = '0; a_wdata = '0;
    b_en = 0; b_we = 0; b_elem = 0; b_addr = '0; b_idx = '0; b_wdata = '0;
  endtask

  task automatic set_a(input logic en, we, el, input int ad, ix, input logic [RowW-1:0] wd);
    a_en = en; a_we = we; a_elem = el; a_addr = AddrW'(ad); a_idx = IdxW'(ix); a_wdata = wd;
  endtask

  task automatic set_b(input logic en, we, el, input int ad, ix, input logic [RowW-1:0] wd);
    b_en = en; b_we = we; b_elem = el; b_addr = AddrW'(ad); b_idx = IdxW'(ix); b_wdata = wd;
  endtask

  task automatic rand_ports(input int span);
    set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, span), $urandom_range(0, NElem - 1), rand_row());
    set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, span), $urandom_range(0, NElem - 1), rand_row());
  endtask

  // One clock with the currently driven requests; the model applies B then A after reads.
  task automatic cycle();
    logic a_rd, b_rd, idle;
    idle = (busy_left == 0);
    check("busy", RowW'(busy), RowW'(!idle));
    a_rd = idle && a_en && !a_we;
    b_rd = idle && b_en && !b_we;
    if (a_rd) exp_a = ref_mem[a_addr];
    if (b_rd) exp_b = ref_mem[b_addr];
    if (idle) begin
      if (b_en && b_we) ref_mem[b_addr] = apply_write(ref_mem[b_addr], b_elem, b_idx, b_wdata);
      if (a_en && a_we) ref_mem[a_addr] = apply_write(ref_mem[a_addr], a_elem, a_idx, a_wdata);
    end
    @(posedge clk);
    #1;
    if (busy_left > 0) busy_left--;
    check("a_rvalid", RowW'(a_rvalid), RowW'(a_rd));
    check("b_rvalid", RowW'(b_rvalid), RowW'(b_rd));
    check("a_rdata", a_rdata, exp_a);
    check("b_rdata", b_rdata, exp_b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
    exp_a = '0;
    exp_b = '0;
    busy_left = Depth;
    check("rst_busy", RowW'(busy), RowW'(1'b1));
    check("rst_a_rvalid", RowW'(a_rvalid), '0);
    check("rst_b_rvalid", RowW'(b_rvalid), '0);
    check("rst_a_rdata", a_rdata, '0);
    check("rst_b_rdata", b_rdata, '0);
  endtask

  task automatic busy_phase(input int n);
    for (int i = 0; i < n; i++) begin
      rand_ports(Depth - 1);
      cycle();
    end
    idle_ports();
  endtask

  logic [RowW-1:0] pat, ones;

  initial begin
    idle_ports();
    ones = '1;
    do_reset();
    busy_phase(Depth);
    check("busy_fell", RowW'(busy), '0);

    // Cleared rows read back as zero on both ports.
    for (int r = 0; r < 3; r++) begin
      set_a(1, 0, 0, r * 15 + (r == 2 ? 1 : 0), 0, '0);
      set_b(1, 0, 0, 31 - r * 15 - (r == 2 ? 1 : 0), 0, '0);
      cycle();
    end
    idle_ports();

    for (int i = 0; i < NElem; i++) pat[i*ElemW +: ElemW] = i + 1;
    set_a(1, 1, 0, 5, 0, pat);
    cycle();
    idle_ports();
    set_b(1, 0, 0, 5, 0, '0);
    cycle();
    check("row5_pattern", b_rdata, pat);

    set_a(1, 1, 1, 3, 2, RowW'(32'hDEAD_BEEF));
    set_b(1, 1, 1, 3, 7, RowW'(32'h1234_5678));
    cycle();
    idle_ports();
    set_a(1, 0, 0, 3, 0, '0);
    cycle();
    check("row3_two_elems", a_rdata, (RowW'(32'hDEAD_BEEF) << 64) | (RowW'(32'h1234_5678) << 224));

    set_a(1, 1, 0, 9, 0, ones);
    set_b(1, 1, 0, 9, 0, '0);
    cycle();
    idle_ports();
    set_b(1, 0, 0, 9, 0, '0);
    cycle();
    check("row9_a_wins", b_rdata, ones);

    set_a(1, 1, 1, 9, 4, RowW'(32'hAAAA_5555));
    set_b(1, 1, 1, 9, 4, RowW'(32'h0F0F_F0F0));
    cycle();
    idle_ports();
    set_a(1, 0, 0, 9, 0, '0);
    cycle();
    check("row9_elem_a_wins", a_rdata[4*ElemW +: ElemW], RowW'(32'hAAAA_5555));

    set_a(1, 1, 0, 12, 0, pat);
    cycle();
    set_a(1, 0, 0, 12, 0, '0);
    set_b(1, 1, 0, 12, 0, ~pat);
    cycle();
    check("row12_read_first", a_rdata, pat);
    idle_ports();
    set_a(1, 0, 0, 12, 0, '0);
    cycle();
    check("row12_new", a_rdata, ~pat);
    idle_ports();

    for (int n = 0; n < 800; n++) begin
      rand_ports(n < 400 ? 3 : Depth - 1);
      cycle();
    end
    idle_ports();

    // Reset mid-clear must restart the full clear sequence.
    do_reset();
    busy_phase(10);
    do_reset();
    busy_phase(Depth);
    check("busy_fell2", RowW'(busy), '0);
    for (int r = 0; r < Depth; r++) begin
      set_a(1, 0, 0, r, 0, '0);
      set_b(1, 0, 0, Depth - 1 - r, 0, '0);
      cycle();
    end
    idle_ports();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
